// File: rtl/common_params.sv
// rtl/common_params.sv - shared width, shift op encoding and arbiter state type
package common_params;

    localparam int BITS = 32;

    typedef logic [1:0] shift_t;
    localparam shift_t SH_SLL = 2'b00;
    localparam shift_t SH_SRL = 2'b01;
    localparam shift_t SH_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/shifter.sv
// rtl/shifter.sv - combinational barrel shifter (SLL / SRL / SRA)
module shifter
    import common_params::*;
#(
    parameter int BITS = common_params::BITS
) (
    input  logic [BITS-1:0]         i_data,
    input  logic [$clog2(BITS)-1:0] i_shamt,
    input  shift_t                  i_op,
    output logic [BITS-1:0]         o_result
);

    // Encoding 2'b10 is not a defined op and simply falls through to a left shift.
    always_comb begin
        case (i_op)
            SH_SRL:  o_result = i_data >> i_shamt;
            SH_SRA:  o_result = $unsigned($signed(i_data) >>> i_shamt);
            default: o_result = i_data << i_shamt;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one shifter between two requesters
module shift_arbiter
    import common_params::*;
#(
    parameter int BITS = common_params::BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [BITS-1:0]         req_data0,
    input  logic [BITS-1:0]         req_data1,
    input  logic [$clog2(BITS)-1:0] req_shamt0,
    input  logic [$clog2(BITS)-1:0] req_shamt1,
    input  shift_t                  req_op0,
    input  shift_t                  req_op1,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [BITS-1:0]         rsp_data,
    output logic                    busy
);

    arb_state_t                r_state;
    arb_state_t                w_next;
    logic                      r_last;
    logic                      r_gnt;
    logic [BITS-1:0]           r_data;
    logic [$clog2(BITS)-1:0]   r_shamt;
    shift_t                    r_op;
    logic [BITS-1:0]           r_rsp;
    logic                      w_gnt_idx;
    logic                      w_accept;
    logic [BITS-1:0]           w_shift;

    // With both valid the requester not granted last wins; a lone requester always wins.
    always_comb begin
        w_gnt_idx = req_valid[1];
        if (req_valid == 2'b11) begin
            w_gnt_idx = ~r_last;
        end
        w_accept = (r_state == IDLE) && (|req_valid) && !rst;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next    = EXEC;
                    req_ready = w_gnt_idx ? 2'b10 : 2'b01;
                end
            end
            EXEC: w_next = RESP;
            RESP: begin
                rsp_valid = r_gnt ? 2'b10 : 2'b01;
                if (rsp_ready[r_gnt]) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pointer resets to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_op    <= SH_SLL;
            r_rsp   <= '0;
        end else begin
            if (w_accept) begin
                r_last  <= w_gnt_idx;
                r_gnt   <= w_gnt_idx;
                r_data  <= w_gnt_idx ? req_data1  : req_data0;
                r_shamt <= w_gnt_idx ? req_shamt1 : req_shamt0;
                r_op    <= w_gnt_idx ? req_op1    : req_op0;
            end
            if (r_state == EXEC) begin
                r_rsp <= w_shift;
            end
        end
    end

    shifter #(
        .BITS(BITS)
    ) u_shifter (
        .i_data  (r_data),
        .i_shamt (r_shamt),
        .i_op    (r_op),
        .o_result(w_shift)
    );

    assign rsp_data = r_rsp;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed vector bench for shift_arbiter
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_data0, req_data1;
    logic [4:0]  req_shamt0, req_shamt1;
    logic [1:0]  req_op0, req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    shift_arbiter #(.BITS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_shamt0(req_shamt0),
        .req_shamt1(req_shamt1),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input int idx, input vec_t v);
        logic [1:0] oh;
        int n;
        oh = v.who ? 2'b10 : 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        if (v.who) begin
            req_data1 = v.data; req_shamt1 = v.shamt; req_op1 = v.op;
        end else begin
            req_data0 = v.data; req_shamt0 = v.shamt; req_op0 = v.op;
        end
        req_valid = oh;
        #1;
        n = 0;
        while (req_ready !== oh && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check($sformatf("v%0d accept", idx), {30'd0, req_ready}, {30'd0, oh});
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check($sformatf("v%0d exec busy", idx), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d exec rsp_valid", idx), {30'd0, rsp_valid}, 32'd0);
        @(negedge clk); #1;
        check($sformatf("v%0d rsp_valid", idx), {30'd0, rsp_valid}, {30'd0, oh});
        check($sformatf("v%0d rsp_data", idx), rsp_data, v.exp);
        rsp_ready = ~oh;
        @(negedge clk); #1;
        check($sformatf("v%0d other ready ignored", idx), {30'd0, rsp_valid}, {30'd0, oh});
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        check($sformatf("v%0d rsp cleared", idx), {30'd0, rsp_valid}, 32'd0);
        check($sformatf("v%0d idle busy", idx), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0] rr_exp[4];
        int k;
        int n;

        vecs[0]  = '{1'b0, 32'h0000_0001,  5'd4, 2'b00, 32'h0000_0010};
        vecs[1]  = '{1'b1, 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
        vecs[3]  = '{1'b0, 32'hA5A5_A5A5,  5'd0, 2'b00, 32'hA5A5_A5A5};
        vecs[4]  = '{1'b1, 32'hA5A5_A5A5,  5'd0, 2'b01, 32'hA5A5_A5A5};
        vecs[5]  = '{1'b0, 32'hA5A5_A5A5,  5'd0, 2'b11, 32'hA5A5_A5A5};
        vecs[6]  = '{1'b0, 32'hF000_0000,  5'd4, 2'b11, 32'hFF00_0000};
        vecs[7]  = '{1'b1, 32'h1234_5678,  5'd8, 2'b01, 32'h0012_3456};
        vecs[8]  = '{1'b0, 32'h1234_5678,  5'd8, 2'b00, 32'h3456_7800};
        vecs[9]  = '{1'b1, 32'h7FFF_FFFF,  5'd1, 2'b11, 32'h3FFF_FFFF};
        vecs[10] = '{1'b0, 32'h8000_0001, 5'd31, 2'b00, 32'h8000_0000};

        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_data0 = 32'h0; req_data1 = 32'h0;
        req_shamt0 = 5'd0; req_shamt1 = 5'd0;
        req_op0 = 2'b00; req_op1 = 2'b00;
        @(negedge clk); #1;
        check("reset req_ready", {30'd0, req_ready}, 32'd0);
        check("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(i, vecs[i]);
        end

        // Both requesters valid from reset: grants must alternate starting at 0.
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_data0 = 32'd1; req_shamt0 = 5'd1; req_op0 = 2'b00;
        req_data1 = 32'd4; req_shamt1 = 5'd2; req_op1 = 2'b01;
        @(negedge clk);
        rst = 1'b0;
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        k = 0;
        n = 0;
        while (k < 4 && n < 40) begin
            #1;
            if (rsp_valid != 2'b00) begin
                check($sformatf("rr rsp_data v=%b", rsp_valid), rsp_data,
                      (rsp_valid == 2'b01) ? 32'd2 : 32'd1);
            end
            if (req_ready != 2'b00) begin
                check($sformatf("rr grant %0d", k), {30'd0, req_ready}, {30'd0, rr_exp[k]});
                k++;
            end
            @(negedge clk);
            n++;
        end
        check("rr grant count", k, 32'd4);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);

        // Response stall: requester 0 wins (last grant was 1), result 1<<1 = 2.
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("stall grant", {30'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("stall%0d rsp_valid", c), {30'd0, rsp_valid}, 32'd1);
            check($sformatf("stall%0d rsp_data", c), rsp_data, 32'd2);
            check($sformatf("stall%0d req_ready", c), {30'd0, req_ready}, 32'd0);
            check($sformatf("stall%0d busy", c), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        check("stall released", {30'd0, rsp_valid}, 32'd0);

        // Reset during EXEC: op dropped, pointer restored so requester 0 wins next.
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        check("rst-exec accept", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        check("rst-exec req_ready", {30'd0, req_ready}, 32'd0);
        check("rst-exec rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst-exec rsp_data", rsp_data, 32'd0);
        check("rst-exec busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 2'b11;
        #1;
        check("rst-exec no rsp a", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk); #1;
        check("rst-exec no rsp b", {30'd0, rsp_valid}, 32'd0);
        req_valid = 2'b11;
        #1;
        check("rst-exec next grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 32 (from common_params), datapath width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid (bit 0 = ALU, bit 1 = image coprocessor).
REQ-005 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-006 SHALL have ports req_data0 / req_data1  input  BITS  shift operands.
REQ-007 SHALL have ports req_shamt0 / req_shamt1  input  $clog2(BITS)  shift amounts.
REQ-008 SHALL have ports req_op0 / req_op1  input  shift_t  operations (00 SLL, 01 SRL, 11 SRA).
REQ-009 SHALL have port rsp_valid  output  2  per-requester result valid.
REQ-010 SHALL have port rsp_ready  input  2  per-requester result accept.
REQ-011 SHALL have port rsp_data  output  BITS  result, shared by both requesters; qualified by rsp_valid.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL share one shifter instance between two requesters using a valid/ready handshake on both request and response sides.
REQ-014 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-015 IDLE: if any req_valid is set, SHALL grant exactly one requester, pulse its req_ready for that cycle, capture data/shamt/op into operand registers, and go to EXEC; otherwise SHALL stay in IDLE.
REQ-016 A request SHALL be accepted only in a cycle where req_valid[i] and req_ready[i] are both 1; req_ready SHALL be 0 outside IDLE.
REQ-017 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, it wins regardless of the pointer.
REQ-018 The last-grant pointer SHALL update only on an accepted request.
REQ-019 EXEC: SHALL drive the shifter from the operand registers, register its output into rsp_data, and go to RESP unconditionally.
REQ-020 RESP: SHALL assert rsp_valid[granted] only; rsp_data and rsp_valid SHALL hold stable until rsp_ready[granted] is 1, then go to IDLE with rsp_valid cleared the next cycle.
REQ-021 rsp_ready of the non-granted requester SHALL be ignored.
REQ-022 Latency SHALL be 2 cycles from accept edge to rsp_valid; throughput SHALL be at most one operation per 3 cycles.
REQ-023 op 2'b10 SHALL be forwarded to the shifter unchanged, with no checking; the result is whatever the shifter produces.
REQ-024 shamt 0 SHALL return the operand unchanged for every op.
REQ-025 req_valid deasserting while not granted SHALL be permitted; no request state is retained.

Reset
REQ-026 While rst is asserted: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 0, operand registers = 0, and pointer = requester 1 so that requester 0 wins the first contention.
REQ-027 Reset asserted in EXEC or RESP SHALL drop the in-flight operation with no response issued.

Structure
REQ-028 BITS and shift_t SHALL remain in common_params, and the state enum arb_state_t SHALL be added there.
REQ-029 SHALL instantiate the existing shifter module as its only sub-module, with all arbitration, FSM and registers in shift_arbiter.

Verification
REQ-030 Requester 0 sends 0x0000_0001, shamt 4, SLL -> rsp_valid[0] 2 cycles after accept, rsp_data = 0x0000_0010.
REQ-031 Requester 1 sends 0x8000_0000, shamt 31, SRA -> rsp_data = 0xFFFF_FFFF; same with SRL -> 0x0000_0001.
REQ-032 Both requesters hold valid continuously from reset -> grants are 0, 1, 0, 1 over four operations, with no double grant.
REQ-033 rsp_ready low for 5 cycles during RESP -> rsp_valid and rsp_data stable throughout, req_ready = 2'b00, busy = 1.
REQ-034 rst asserted during EXEC -> next cycle all outputs 0, no rsp_valid, and the next contention is granted to requester 0.
REQ-035 shamt 0 with each of SLL, SRL and SRA on 0xA5A5_A5A5 -> rsp_data = 0xA5A5_A5A5.
